// File: rtl/mem_stage_if.sv
// Handshake and payload signals around the MEM pipeline stage.
// master is the MEM stage itself; slave is the surrounding EX/WB/SRAM/ID side.
interface mem_stage_if #(
    parameter int EX_MEM_W = 236,
    parameter int MEM_WB_W = 231
);
    logic                ex_mem_valid;
    logic [EX_MEM_W-1:0] ex_mem_bus;
    logic                mem_allowin;
    logic [31:0]         data_sram_rdata;
    logic                mem_wb_valid;
    logic [MEM_WB_W-1:0] mem_wb_bus;
    logic                wb_allowin;
    logic                flush;
    logic [38:0]         mem_id_bus;
    logic                mem_ex_block;

    modport master (
        input  ex_mem_valid, ex_mem_bus, data_sram_rdata, wb_allowin, flush,
        output mem_allowin, mem_wb_valid, mem_wb_bus, mem_id_bus, mem_ex_block
    );

    modport slave (
        output ex_mem_valid, ex_mem_bus, data_sram_rdata, wb_allowin, flush,
        input  mem_allowin, mem_wb_valid, mem_wb_bus, mem_id_bus, mem_ex_block
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: latches the EX payload, captures/holds the load response,
// extracts and extends load data, and drives WB and the ID forwarding bus.
module mem_stage #(
    parameter int EX_MEM_W = 236,
    parameter int MEM_WB_W = 231
) (
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.master io
);
    localparam logic MEM_READY_GO = 1'b1;

    typedef struct packed {
        logic        gr_we;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu_result;
        logic [4:0]  dest;
        logic [4:0]  ld_op;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
    } ex_mem_t;

    logic                mem_valid_q, mem_valid_d;
    logic                first_cyc_q, first_cyc_d;
    logic [EX_MEM_W-1:0] bus_q;
    logic [31:0]         rdata_buf_q;

    logic                mem_allowin;
    logic                accept;
    ex_mem_t             cur;
    logic [31:0]         ld_raw;
    logic [7:0]          lane [4];
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [31:0]         ld_data;
    logic [31:0]         final_result;
    logic [MEM_WB_W-1:0] wb_bus;

    assign mem_allowin = ~mem_valid_q | (MEM_READY_GO & io.wb_allowin);
    assign accept      = io.ex_mem_valid & mem_allowin & ~io.flush;

    always_comb begin
        mem_valid_d = mem_valid_q;
        if (io.flush)
            mem_valid_d = 1'b0;
        else if (mem_allowin)
            mem_valid_d = io.ex_mem_valid;
    end

    assign first_cyc_d = accept;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            first_cyc_q <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            first_cyc_q <= first_cyc_d;
        end
    end

    // Payload and captured load data carry no reset; they are qualified by mem_valid_q.
    always_ff @(posedge clk) begin
        if (accept)
            bus_q <= io.ex_mem_bus;
        if (mem_valid_q & first_cyc_q)
            rdata_buf_q <= io.data_sram_rdata;
    end

    assign cur    = bus_q;
    assign ld_raw = first_cyc_q ? io.data_sram_rdata : rdata_buf_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = ld_raw[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = lane[cur.alu_result[1:0]];
    // Halfword loads are aligned upstream, so only off[1] picks the half.
    assign ld_half = cur.alu_result[1] ? ld_raw[31:16] : ld_raw[15:0];

    always_comb begin
        ld_data = ld_raw;
        if (cur.ld_op[4])
            ld_data = {{24{ld_byte[7]}}, ld_byte};
        else if (cur.ld_op[3])
            ld_data = {24'd0, ld_byte};
        else if (cur.ld_op[2])
            ld_data = {{16{ld_half[15]}}, ld_half};
        else if (cur.ld_op[1])
            ld_data = {16'd0, ld_half};
    end

    assign final_result = (|cur.ld_op) ? ld_data : cur.alu_result;

    assign wb_bus = {cur.gr_we, cur.pc, cur.inst, final_result, cur.dest,
                     cur.csr_we, cur.csr_re, cur.csr_num, cur.csr_wmask, cur.csr_wvalue,
                     cur.ertn, cur.ex, cur.ecode, cur.esubcode, cur.badv};

    assign io.mem_allowin  = mem_allowin;
    assign io.mem_wb_valid = mem_valid_q & MEM_READY_GO;
    assign io.mem_wb_bus   = wb_bus;
    assign io.mem_id_bus   = {mem_valid_q & cur.gr_we, cur.dest, final_result,
                              mem_valid_q & (cur.csr_re | cur.csr_we)};
    assign io.mem_ex_block = mem_valid_q & (cur.ex | cur.ertn);
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected WB/ID payloads,
// an independent monitor pops and compares on every WB transfer.
module tb_mem_stage;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if #(.EX_MEM_W(236), .MEM_WB_W(231)) bus_if ();

    mem_stage #(.EX_MEM_W(236), .MEM_WB_W(231)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io     (bus_if)
    );

    typedef struct packed {
        logic        gr_we;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu_result;
        logic [4:0]  dest;
        logic [4:0]  ld_op;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
    } ins_t;

    typedef struct {
        logic [230:0] wb;
        logic [38:0]  id;
        logic [31:0]  pc;
    } exp_t;

    exp_t q[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b00010;
    localparam logic [4:0] LD_W  = 5'b00001;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic ins_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                input logic [4:0] dest, input logic [4:0] ld_op, input logic gr_we);
        ins_t i;
        i            = '0;
        i.gr_we      = gr_we;
        i.pc         = pc;
        i.inst       = 32'h2880_0000 ^ pc;
        i.alu_result = alu;
        i.dest       = dest;
        i.ld_op      = ld_op;
        i.badv       = 32'h5A5A_0000 | pc[15:0];
        return i;
    endfunction

    function automatic logic [230:0] wb_of(input ins_t i, input logic [31:0] fr);
        return {i.gr_we, i.pc, i.inst, fr, i.dest, i.csr_we, i.csr_re, i.csr_num,
                i.csr_wmask, i.csr_wvalue, i.ertn, i.ex, i.ecode, i.esubcode, i.badv};
    endfunction

    // Presents i at posedge+1, drives the SRAM response in the cycle after accept.
    task automatic issue(input ins_t i, input logic [31:0] rdata, input logic [31:0] exp_fr, input bit push);
        exp_t e;
        bus_if.ex_mem_valid = 1'b1;
        bus_if.ex_mem_bus   = i;
        if (push) begin
            e.wb = wb_of(i, exp_fr);
            e.id = {i.gr_we, i.dest, exp_fr, i.csr_re | i.csr_we};
            e.pc = i.pc;
            q.push_back(e);
        end
        @(negedge clk);
        check("allowin_before_accept", 256'(bus_if.mem_allowin), 256'(1'b1));
        @(posedge clk); #1;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.data_sram_rdata = rdata;
        @(negedge clk);
        check("wb_valid_after_accept", 256'(bus_if.mem_wb_valid), 256'(1'b1));
    endtask

    // Scoreboard monitor: every WB transfer must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && bus_if.mem_wb_valid === 1'b1 && bus_if.wb_allowin === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_wb_output", 256'(1'b1), 256'(1'b0));
                end else begin
                    e = q.pop_front();
                    check("mem_wb_bus", 256'(bus_if.mem_wb_bus), 256'(e.wb));
                    check("mem_id_bus", 256'(bus_if.mem_id_bus), 256'(e.id));
                    $display("txn pc=%08h result=%08h id=%010h", e.pc,
                             bus_if.mem_wb_bus[165:134], bus_if.mem_id_bus);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ins_t a;
        ins_t b;
        resetn                 = 1'b0;
        bus_if.ex_mem_valid    = 1'b0;
        bus_if.ex_mem_bus      = '0;
        bus_if.data_sram_rdata = '0;
        bus_if.wb_allowin      = 1'b1;
        bus_if.flush           = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_wb_valid",   256'(bus_if.mem_wb_valid), 256'(1'b0));
        check("reset_allowin",    256'(bus_if.mem_allowin),  256'(1'b1));
        check("reset_ex_block",   256'(bus_if.mem_ex_block), 256'(1'b0));
        check("reset_rf_we",      256'(bus_if.mem_id_bus[38]), 256'(1'b0));
        check("reset_csr_hazard", 256'(bus_if.mem_id_bus[0]),  256'(1'b0));
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Load extraction vectors
        issue(mk(32'h1C00_0000, 32'h0000_1003, 5'd4, LD_B,  1'b1), 32'h80FF_1234, 32'hFFFF_FF80, 1'b1);
        @(posedge clk); #1;
        issue(mk(32'h1C00_0004, 32'h0000_1003, 5'd4, LD_BU, 1'b1), 32'h80FF_1234, 32'h0000_0080, 1'b1);
        @(posedge clk); #1;
        issue(mk(32'h1C00_0008, 32'h0000_1000, 5'd6, LD_B,  1'b1), 32'h80FF_1234, 32'h0000_0034, 1'b1);
        @(posedge clk); #1;
        issue(mk(32'h1C00_000C, 32'h0000_1001, 5'd6, LD_B,  1'b1), 32'h80FF_1234, 32'h0000_0012, 1'b1);
        @(posedge clk); #1;
        issue(mk(32'h1C00_0010, 32'h0000_1002, 5'd6, LD_B,  1'b1), 32'h80FF_1234, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        issue(mk(32'h1C00_0014, 32'h0000_1002, 5'd8, LD_H,  1'b1), 32'h8001_7FFF, 32'hFFFF_8001, 1'b1);
        @(posedge clk); #1;
        issue(mk(32'h1C00_0018, 32'h0000_1002, 5'd8, LD_HU, 1'b1), 32'h8001_7FFF, 32'h0000_8001, 1'b1);
        @(posedge clk); #1;
        issue(mk(32'h1C00_001C, 32'h0000_1000, 5'd8, LD_H,  1'b1), 32'h8001_7FFF, 32'h0000_7FFF, 1'b1);
        @(posedge clk); #1;
        issue(mk(32'h1C00_0020, 32'h0000_1000, 5'd9, LD_W,  1'b1), 32'h8001_7FFF, 32'h8001_7FFF, 1'b1);
        @(posedge clk); #1;

        // Stall: load data must survive a WB backpressure of three cycles
        bus_if.wb_allowin = 1'b0;
        issue(mk(32'h1C00_0024, 32'h0000_2000, 5'd10, LD_W, 1'b1), 32'h1234_5678, 32'h1234_5678, 1'b1);
        check("stall_c1_result",  256'(bus_if.mem_wb_bus[165:134]), 256'(32'h1234_5678));
        check("stall_c1_allowin", 256'(bus_if.mem_allowin), 256'(1'b0));
        a = mk(32'h1C00_0028, 32'h0000_0042, 5'd5, 5'b0, 1'b1);
        @(posedge clk); #1;
        bus_if.data_sram_rdata = 32'hDEAD_BEEF;
        bus_if.ex_mem_valid    = 1'b1;
        bus_if.ex_mem_bus      = a;
        @(negedge clk);
        check("stall_c2_result",  256'(bus_if.mem_wb_bus[165:134]), 256'(32'h1234_5678));
        check("stall_c2_allowin", 256'(bus_if.mem_allowin), 256'(1'b0));
        @(negedge clk);
        check("stall_c3_result",  256'(bus_if.mem_wb_bus[165:134]), 256'(32'h1234_5678));
        check("stall_c3_allowin", 256'(bus_if.mem_allowin), 256'(1'b0));
        check("stall_c3_valid",   256'(bus_if.mem_wb_valid), 256'(1'b1));
        @(posedge clk); #1;
        bus_if.wb_allowin = 1'b1;
        issue(a, 32'h0000_0000, 32'h0000_0042, 1'b1);
        check("add_forward", 256'(bus_if.mem_id_bus), 256'({1'b1, 5'd5, 32'h0000_0042, 1'b0}));
        @(posedge clk); #1;

        // Exception held in MEM, then flush races a new EX instruction
        a = mk(32'h1C00_002C, 32'h0000_ABCD, 5'd3, 5'b0, 1'b0);
        a.ex       = 1'b1;
        a.ecode    = 6'h0B;
        a.esubcode = 9'h1A5;
        a.badv     = 32'hCAFE_F00D;
        bus_if.wb_allowin = 1'b0;
        issue(a, 32'h0, 32'h0000_ABCD, 1'b1);
        check("ex_block_set", 256'(bus_if.mem_ex_block), 256'(1'b1));
        check("ex_rf_we_clear", 256'(bus_if.mem_id_bus[38]), 256'(1'b0));
        @(posedge clk); #1;
        b = mk(32'h1C00_0030, 32'h0000_0777, 5'd12, 5'b0, 1'b1);
        bus_if.flush        = 1'b1;
        bus_if.ex_mem_valid = 1'b1;
        bus_if.ex_mem_bus   = b;
        bus_if.wb_allowin   = 1'b1;
        @(negedge clk);
        check("flush_cycle_allowin", 256'(bus_if.mem_allowin), 256'(1'b1));
        @(posedge clk); #1;
        bus_if.flush        = 1'b0;
        bus_if.ex_mem_valid = 1'b0;
        @(negedge clk);
        check("flush_no_accept",  256'(bus_if.mem_wb_valid), 256'(1'b0));
        check("flush_ex_block",   256'(bus_if.mem_ex_block), 256'(1'b0));
        @(posedge clk); #1;

        // CSR read in MEM raises the ID hazard flag
        a = mk(32'h1C00_0034, 32'h0000_0000, 5'd7, 5'b0, 1'b1);
        a.csr_re  = 1'b1;
        a.csr_num = 14'h0005;
        bus_if.wb_allowin = 1'b0;
        issue(a, 32'h0, 32'h0000_0000, 1'b1);
        check("csr_hazard_set", 256'(bus_if.mem_id_bus[0]), 256'(1'b1));
        @(posedge clk); #1;
        bus_if.wb_allowin = 1'b1;
        @(posedge clk); #1;

        // Reset while a load is held in MEM
        bus_if.wb_allowin = 1'b0;
        issue(mk(32'h1C00_0038, 32'h0000_3000, 5'd11, LD_W, 1'b1), 32'h0BAD_0BAD, 32'h0BAD_0BAD, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_wb_valid",   256'(bus_if.mem_wb_valid), 256'(1'b0));
        check("rst_mid_allowin",    256'(bus_if.mem_allowin),  256'(1'b1));
        check("rst_mid_rf_we",      256'(bus_if.mem_id_bus[38]), 256'(1'b0));
        check("rst_mid_csr_hazard", 256'(bus_if.mem_id_bus[0]),  256'(1'b0));
        check("rst_mid_ex_block",   256'(bus_if.mem_ex_block), 256'(1'b0));
        @(posedge clk); #1;
        resetn = 1'b1;
        bus_if.wb_allowin = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 256'(q.size()), 256'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
